// File: rtl/sram_like_pkg.sv
// Shared types for the sram-like arbiter: port owner tag, request bundle, size codes.
package sram_like_pkg;

  localparam int SRAM_ADDR_W = 32;
  localparam int SRAM_DATA_W = 32;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic {OWN_INST = 1'b0, OWN_DATA = 1'b1} owner_e;

  typedef enum logic {LK_IDLE = 1'b0, LK_HELD = 1'b1} lock_e;

  typedef struct packed {
    logic                   wr;
    logic [1:0]             size;
    logic [SRAM_ADDR_W-1:0] addr;
    logic [SRAM_DATA_W-1:0] wdata;
  } sram_req_t;

endpackage

// File: rtl/sram_like_arbiter_owner_fifo.sv
// In-order FIFO of owner tags for accepted-but-unanswered transactions.
module owner_fifo
  import sram_like_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  owner_e push_owner,
  input  logic   pop,
  output logic   full,
  output logic   empty,
  output owner_e head
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q;
  owner_e        mem_q [DEPTH];

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_owner;
  end

  assign full  = (count_q == (PW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one sram-like port between inst and data masters; responses routed in order.
// Optional ARB_ROUND_ROBIN_EN: alternate grants on contention instead of data>inst priority.
module sram_like_arbiter
  import sram_like_pkg::*;
#(
  parameter int OUTSTANDING = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              m_req,
  output logic              m_wr,
  output logic [1:0]        m_size,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_addr_ok,
  input  logic              m_data_ok,
  input  logic [DATA_W-1:0] m_rdata
);

  sram_req_t inst_r, data_r, sel_r;
  lock_e     lock_q, lock_d;
  owner_e    lock_own_q, lock_own_d;
  owner_e    gnt, fifo_head;
  logic      gnt_vld, accept, pop, fifo_full, fifo_empty;

  assign inst_r = '{wr: inst_wr, size: inst_size,
                    addr: SRAM_ADDR_W'(inst_addr), wdata: SRAM_DATA_W'(inst_wdata)};
  assign data_r = '{wr: data_wr, size: data_size,
                    addr: SRAM_ADDR_W'(data_addr), wdata: SRAM_DATA_W'(data_wdata)};

`ifdef ARB_ROUND_ROBIN_EN
  owner_e last_q;

  always_ff @(posedge clk) begin
    if (!rst_n)      last_q <= OWN_INST;
    else if (accept) last_q <= gnt;
  end
`endif

  // Full is the registered count: a pop this cycle does not free a slot until next cycle.
  always_comb begin
    gnt     = OWN_DATA;
    gnt_vld = 1'b0;
    if (rst_n && !fifo_full) begin
      if (lock_q == LK_HELD) begin
        gnt     = lock_own_q;
        gnt_vld = 1'b1;
      end else if (data_req && inst_req) begin
`ifdef ARB_ROUND_ROBIN_EN
        gnt = (last_q == OWN_INST) ? OWN_DATA : OWN_INST;
`else
        gnt = OWN_DATA;
`endif
        gnt_vld = 1'b1;
      end else if (data_req) begin
        gnt     = OWN_DATA;
        gnt_vld = 1'b1;
      end else if (inst_req) begin
        gnt     = OWN_INST;
        gnt_vld = 1'b1;
      end
    end
  end

  assign sel_r   = (gnt == OWN_DATA) ? data_r : inst_r;
  assign m_req   = gnt_vld & ((gnt == OWN_DATA) ? data_req : inst_req);
  assign m_wr    = m_req & sel_r.wr;
  assign m_size  = m_req ? sel_r.size : 2'b00;
  assign m_addr  = m_req ? ADDR_W'(sel_r.addr) : '0;
  assign m_wdata = m_req ? DATA_W'(sel_r.wdata) : '0;

  assign accept       = m_req & m_addr_ok;
  assign inst_addr_ok = accept & (gnt == OWN_INST);
  assign data_addr_ok = accept & (gnt == OWN_DATA);

  always_comb begin
    lock_d     = lock_q;
    lock_own_d = lock_own_q;
    case (lock_q)
      LK_IDLE: if (m_req && !m_addr_ok) begin
        lock_d     = LK_HELD;
        lock_own_d = gnt;
      end
      LK_HELD: if (accept) lock_d = LK_IDLE;
      default: lock_d = LK_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_q     <= LK_IDLE;
      lock_own_q <= OWN_INST;
    end else begin
      lock_q     <= lock_d;
      lock_own_q <= lock_own_d;
    end
  end

  // Responses with nothing outstanding are dropped.
  assign pop          = rst_n & m_data_ok & ~fifo_empty;
  assign inst_data_ok = pop & (fifo_head == OWN_INST);
  assign data_data_ok = pop & (fifo_head == OWN_DATA);
  assign inst_rdata   = m_rdata;
  assign data_rdata   = m_rdata;

  owner_fifo #(.DEPTH(OUTSTANDING)) u_owner_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (accept),
    .push_owner (gnt),
    .pop        (pop),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .head       (fifo_head)
  );

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed self-checking bench for sram_like_arbiter (default and ARB_ROUND_ROBIN_EN builds).
module tb_sram_like_arbiter;

  logic        clk, rst_n;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size, m_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        m_req, m_wr, m_addr_ok, m_data_ok;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  oks;
  int          checks = 0;
  int          errors = 0;

  assign oks = {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok};

  sram_like_arbiter #(.OUTSTANDING(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs;
    inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = 0; data_wdata = 0;
    m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
  endtask

  task automatic test_reset;
    rst_n = 0; idle_inputs();
    @(negedge clk);
    inst_req = 1; data_req = 1; data_addr = 32'h10; m_addr_ok = 1; m_data_ok = 1;
    #1;
    checks++; if (m_req !== 1'b0 || m_addr !== 32'h0) begin errors++;
      $display("FAIL reset_mreq: got req=%b addr=%h exp req=0 addr=0", m_req, m_addr); end
    checks++; if (oks !== 4'b0000) begin errors++;
      $display("FAIL reset_oks: got %b exp 0000", oks); end
    @(negedge clk);
    idle_inputs(); rst_n = 1;
    #1;
    checks++; if (m_req !== 1'b0) begin errors++;
      $display("FAIL reset_idle: got m_req=%b exp 0", m_req); end
  endtask

  task automatic test_both_req;
    @(negedge clk);
    inst_req = 1; inst_addr = 32'h100;
    data_req = 1; data_addr = 32'h200; data_wr = 1; data_size = 2'd2; data_wdata = 32'hDEADBEEF;
    m_addr_ok = 1;
    #1;
    checks++; if (m_addr !== 32'h200 || oks !== 4'b0100) begin errors++;
      $display("FAIL both_first: got addr=%h oks=%b exp 200/0100", m_addr, oks); end
    checks++; if ({m_req, m_wr, m_size} !== 4'b1110 || m_wdata !== 32'hDEADBEEF) begin errors++;
      $display("FAIL both_mux: got %b wdata=%h exp 1110/deadbeef", {m_req, m_wr, m_size}, m_wdata); end
    @(negedge clk);
`ifndef ARB_ROUND_ROBIN_EN
    data_req = 0;
`endif
    #1;
    checks++; if (m_addr !== 32'h100 || oks !== 4'b1000 || m_wr !== 1'b0) begin errors++;
      $display("FAIL both_second: got addr=%h oks=%b wr=%b exp 100/1000/0", m_addr, oks, m_wr); end
    @(negedge clk);
    inst_req = 0; data_req = 0; data_wr = 0; m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'hA5;
    #1;
    checks++; if (m_req !== 1'b0 || oks !== 4'b0001 || data_rdata !== 32'hA5 || inst_rdata !== 32'hA5) begin errors++;
      $display("FAIL both_resp0: got req=%b oks=%b rdata=%h exp 0/0001/a5", m_req, oks, data_rdata); end
    @(negedge clk); #1;
    checks++; if (oks !== 4'b0010) begin errors++;
      $display("FAIL both_resp1: got %b exp 0010", oks); end
    @(negedge clk); m_data_ok = 0;
  endtask

  task automatic test_hold;
    logic [3:0] exp_seq [4];
    exp_seq = '{4'b0001, 4'b0010, 4'b0010, 4'b0001};
    @(negedge clk);
    data_req = 1; data_addr = 32'h300; m_addr_ok = 0;
    #1;
    checks++; if (m_req !== 1'b1 || m_addr !== 32'h300 || oks !== 4'b0000) begin errors++;
      $display("FAIL hold_c0: got req=%b addr=%h oks=%b exp 1/300/0000", m_req, m_addr, oks); end
    @(negedge clk); #1;
    checks++; if (m_addr !== 32'h300) begin errors++;
      $display("FAIL hold_c1: got addr=%h exp 300", m_addr); end
    @(negedge clk);
    inst_req = 1; inst_addr = 32'h104;
    #1;
    checks++; if (m_addr !== 32'h300 || oks !== 4'b0000) begin errors++;
      $display("FAIL hold_c2: got addr=%h oks=%b exp 300/0000", m_addr, oks); end
    @(negedge clk);
    m_addr_ok = 1;
    #1;
    checks++; if (m_addr !== 32'h300 || oks !== 4'b0100) begin errors++;
      $display("FAIL hold_acc: got addr=%h oks=%b exp 300/0100", m_addr, oks); end
    @(negedge clk);
    data_req = 0;
    #1;
    checks++; if (m_addr !== 32'h104 || oks !== 4'b1000) begin errors++;
      $display("FAIL hold_inst: got addr=%h oks=%b exp 104/1000", m_addr, oks); end
    // inst locked first; a later data_req must not steal the grant
    @(negedge clk);
    inst_addr = 32'h400; m_addr_ok = 0;
    #1;
    checks++; if (m_addr !== 32'h400) begin errors++;
      $display("FAIL lock_c0: got addr=%h exp 400", m_addr); end
    @(negedge clk);
    data_req = 1; data_addr = 32'h500;
    #1;
    checks++; if (m_addr !== 32'h400 || oks !== 4'b0000) begin errors++;
      $display("FAIL lock_c1: got addr=%h oks=%b exp 400/0000", m_addr, oks); end
    @(negedge clk);
    m_addr_ok = 1;
    #1;
    checks++; if (m_addr !== 32'h400 || oks !== 4'b1000) begin errors++;
      $display("FAIL lock_acc: got addr=%h oks=%b exp 400/1000", m_addr, oks); end
    @(negedge clk);
    inst_req = 0;
    #1;
    checks++; if (m_addr !== 32'h500 || oks !== 4'b0100) begin errors++;
      $display("FAIL lock_data: got addr=%h oks=%b exp 500/0100", m_addr, oks); end
    @(negedge clk);
    data_req = 0; m_addr_ok = 0; m_data_ok = 1;
    for (int i = 0; i < 4; i++) begin
      m_rdata = 32'(i + 1);
      #1;
      checks++; if (oks !== exp_seq[i]) begin errors++;
        $display("FAIL hold_resp%0d: got %b exp %b", i, oks, exp_seq[i]); end
      @(negedge clk);
    end
    m_data_ok = 0;
  endtask

  task automatic test_full;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      inst_req = 1; inst_addr = 32'h1000 + 32'(4 * i); m_addr_ok = 1;
      #1;
      checks++; if (oks !== 4'b1000) begin errors++;
        $display("FAIL full_fill%0d: got %b exp 1000", i, oks); end
    end
    @(negedge clk);
    m_data_ok = 1; m_rdata = 32'h44;
    #1;
    checks++; if (m_req !== 1'b0 || oks !== 4'b0010) begin errors++;
      $display("FAIL full_block: got req=%b oks=%b exp 0/0010", m_req, oks); end
    @(negedge clk);
    m_data_ok = 0;
    #1;
    checks++; if (m_req !== 1'b1 || oks !== 4'b1000) begin errors++;
      $display("FAIL full_fifth: got req=%b oks=%b exp 1/1000", m_req, oks); end
    @(negedge clk);
    inst_req = 0; m_addr_ok = 0; m_data_ok = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (oks !== 4'b0010) begin errors++;
        $display("FAIL full_drain%0d: got %b exp 0010", i, oks); end
      @(negedge clk);
    end
    m_data_ok = 0;
  endtask

  task automatic test_interleave;
    logic [3:0]  exp_ok [3];
    logic [31:0] rd [3];
    exp_ok = '{4'b0010, 4'b0001, 4'b0010};
    rd     = '{32'h11, 32'h22, 32'h33};
    @(negedge clk);
    inst_req = 1; inst_addr = 32'hA0; m_addr_ok = 1;
    #1;
    checks++; if (oks !== 4'b1000) begin errors++; $display("FAIL ilv_a: got %b exp 1000", oks); end
    @(negedge clk);
    inst_req = 0; data_req = 1; data_addr = 32'hB0;
    #1;
    checks++; if (oks !== 4'b0100) begin errors++; $display("FAIL ilv_b: got %b exp 0100", oks); end
    @(negedge clk);
    data_req = 0; inst_req = 1; inst_addr = 32'hC0;
    #1;
    checks++; if (oks !== 4'b1000) begin errors++; $display("FAIL ilv_c: got %b exp 1000", oks); end
    @(negedge clk);
    inst_req = 0; m_addr_ok = 0; m_data_ok = 1;
    for (int i = 0; i < 3; i++) begin
      m_rdata = rd[i];
      #1;
      checks++; if (oks !== exp_ok[i] || (exp_ok[i][1] ? inst_rdata : data_rdata) !== rd[i]) begin errors++;
        $display("FAIL ilv_resp%0d: got oks=%b inst=%h data=%h exp %b/%h", i, oks, inst_rdata, data_rdata, exp_ok[i], rd[i]); end
      @(negedge clk);
    end
    m_data_ok = 0;
  endtask

  task automatic test_push_pop;
    @(negedge clk);
    inst_req = 1; m_addr_ok = 1;
    #1;
    checks++; if (oks !== 4'b1000) begin errors++; $display("FAIL pp_i: got %b exp 1000", oks); end
    @(negedge clk);
    inst_req = 0; data_req = 1;
    #1;
    checks++; if (oks !== 4'b0100) begin errors++; $display("FAIL pp_d: got %b exp 0100", oks); end
    @(negedge clk);
    data_req = 0; inst_req = 1; m_data_ok = 1; m_rdata = 32'h55;
    #1;
    checks++; if (oks !== 4'b1010 || inst_rdata !== 32'h55) begin errors++;
      $display("FAIL pp_both: got oks=%b rdata=%h exp 1010/55", oks, inst_rdata); end
    @(negedge clk);
    inst_req = 0; m_addr_ok = 0;
    #1;
    checks++; if (oks !== 4'b0001) begin errors++; $display("FAIL pp_r1: got %b exp 0001", oks); end
    @(negedge clk); #1;
    checks++; if (oks !== 4'b0010) begin errors++; $display("FAIL pp_r2: got %b exp 0010", oks); end
    @(negedge clk); #1;
    checks++; if (oks !== 4'b0000) begin errors++; $display("FAIL pp_empty: got %b exp 0000", oks); end
    @(negedge clk); m_data_ok = 0;
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    inst_req = 1; m_addr_ok = 1;
    #1;
    checks++; if (oks !== 4'b1000) begin errors++; $display("FAIL rm_i: got %b exp 1000", oks); end
    @(negedge clk);
    inst_req = 0; data_req = 1;
    #1;
    checks++; if (oks !== 4'b0100) begin errors++; $display("FAIL rm_d: got %b exp 0100", oks); end
    @(negedge clk);
    data_req = 0; inst_req = 1; m_addr_ok = 0;
    #1;
    checks++; if (m_req !== 1'b1 || oks !== 4'b0000) begin errors++;
      $display("FAIL rm_lock: got req=%b oks=%b exp 1/0000", m_req, oks); end
    @(negedge clk);
    rst_n = 0; m_addr_ok = 1; m_data_ok = 1;
    #1;
    checks++; if (m_req !== 1'b0 || oks !== 4'b0000) begin errors++;
      $display("FAIL rm_inrst: got req=%b oks=%b exp 0/0000", m_req, oks); end
    @(negedge clk);
    rst_n = 1; inst_req = 0; m_addr_ok = 0; m_data_ok = 1;
    #1;
    checks++; if (m_req !== 1'b0 || oks !== 4'b0000) begin errors++;
      $display("FAIL rm_spurious: got req=%b oks=%b exp 0/0000", m_req, oks); end
    @(negedge clk);
    m_data_ok = 0; data_req = 1; m_addr_ok = 1;
    #1;
    checks++; if (oks !== 4'b0100) begin errors++; $display("FAIL rm_unlock: got %b exp 0100", oks); end
    @(negedge clk);
    data_req = 0; m_addr_ok = 0; m_data_ok = 1;
    #1;
    checks++; if (oks !== 4'b0001) begin errors++; $display("FAIL rm_resp: got %b exp 0001", oks); end
    @(negedge clk); m_data_ok = 0;
  endtask

  initial begin
    test_reset();
    test_both_req();
    test_hold();
    test_full();
    test_interleave();
    test_push_pop();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
